// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults and types for the register-file write arbiter.
// Holds the write-port grant encoding and the default FIFO entry layout.
package rf_write_arbiter_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_AW_DEF     = 5;

  localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } rf_wr_t;

  // Owner of the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// Circular-buffer sync FIFO with registered head; buffer contents are not reset,
// only the pointers and the occupancy counter are.
module rf_write_arbiter_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap on their own because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (always first) and buffered MDU results,
// and keeps a per-register busy scoreboard of outstanding MDU writes for ID hazard stalls.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_AW     = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_reg,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_reg,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic [REG_AW-1:0] rf_wreg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wen,
  output logic              err
);

  localparam int unsigned NREG = 1 << REG_AW;
  localparam int unsigned EW   = REG_AW + DATA_W;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          push_entry;
  entry_t          head;
  logic [EW-1:0]   head_raw;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            wb_own;
  grant_e          grant;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  // MDU handshake: a result transfers in any cycle with mdu_valid && mdu_ready; the producer
  // holds valid/reg/data until then. Ready depends only on FIFO occupancy, never on valid.
  assign mdu_ready  = rst_n && !fifo_full;
  assign push       = mdu_valid && mdu_ready && (mdu_reg != '0);
  assign push_entry = '{rd: mdu_reg, data: mdu_data};
  assign head       = entry_t'(head_raw);

  assign wb_own = wb_valid && (wb_reg != '0);

  always_comb begin
    grant = GNT_NONE;
    if (!rst_n)           grant = GNT_NONE;
    else if (wb_own)      grant = GNT_WB;
    else if (!fifo_empty) grant = GNT_MDU;
  end

  assign pop = (grant == GNT_MDU);

  always_comb begin
    rf_wen   = 1'b0;
    rf_wreg  = '0;
    rf_wdata = '0;
    unique case (grant)
      GNT_WB: begin
        rf_wen   = 1'b1;
        rf_wreg  = wb_reg;
        rf_wdata = wb_data;
      end
      GNT_MDU: begin
        rf_wen   = 1'b1;
        rf_wreg  = head.rd;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  rf_write_arbiter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

  // Clear-on-pop happens before set-on-issue so a same-register collision stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (iss_valid && (iss_reg != '0)) busy_d[iss_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (iss_valid && busy_q[iss_reg] && !(pop && (head.rd == iss_reg))) err_d = 1'b1;
    if (wb_valid && busy_q[wb_reg])                                     err_d = 1'b1;
    if (push && !busy_q[mdu_reg])                                       err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // A register popped this cycle still reads busy; the RF holds its value from next cycle.
  assign busy_rs = busy_q[rs];
  assign busy_rt = busy_q[rt];
  assign err     = err_q;

endmodule
